regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised GPR/FPR register file for the decode stage, with NWB write-back ports, a per-register
//  busy scoreboard and write-back-to-read forwarding. It drives stall for the issuing instruction
//  (RAW and WAW), so decode no longer depends on fixed wait_time counts for multi-cycle FPU ops and loads.
// PARAMETERS
//  XLEN     32           data width
//  NREG     32           registers per bank; AW = $clog2(NREG)
//  NWB      2            write-back ports; higher index has priority
//  ZERO_R0  1            GPR[0] reads 0, writes to it are dropped and never set busy
//  SP_IDX   29           GPR index with non-zero reset value
//  SP_INIT  32'h30       reset value of GPR[SP_IDX]
//  HP_IDX   28           second preset GPR index
//  HP_INIT  32'h000F4240 reset value of GPR[HP_IDX]
//  DBG_IDX  2            GPR index mirrored on dbg_reg
// PORTS
//  clk       in   1          clock; single clock domain
//  rst       in   1          asynchronous reset, active-high
//  rs_addr   in   AW+1       source s: {bank (1=FPR), index}
//  rs_use    in   1          source s is read by the instruction
//  rt_addr   in   AW+1       source t: {bank, index}
//  rt_use    in   1          source t is read
//  s_data    out  XLEN       forwarded read data, source s
//  t_data    out  XLEN       forwarded read data, source t
//  iss_valid in   1          decode presents an instruction
//  iss_rw    in   2          rw_t of the instruction: 00 none, 01 GPR, 10 FPR, 11 treated as none
//  iss_rd    in   AW         destination index
//  stall     out  1          instruction is not accepted this cycle
//  wb_valid  in   NWB        write-back strobes
//  wb_rw     in   2*NWB      target bank per port (rw_t)
//  wb_rd     in   AW*NWB     destination index per port
//  wb_data   in   XLEN*NWB   write data per port
//  pending   out  $clog2(2*NREG+1)  count of busy registers
//  idle      out  1          pending == 0
//  dbg_reg   out  XLEN       architectural (non-forwarded) GPR[DBG_IDX]
// BEHAVIOUR
//  - Reset (async, while rst=1): all FPRs 0. All GPRs 0 except SP_IDX/HP_IDX presets. All busy bits 0,
//    pending=0, idle=1, stall=0.
//  - Reads are combinational. If a wb port in the same cycle hits {bank,index}, s_data/t_data take the
//    highest-index hitting port's data. Otherwise they take the array. GPR[0] with ZERO_R0 is always 0.
//  - Writes happen on posedge when wb_valid[i] and wb_rw[i] is 01 or 10. If several ports hit the same
//    register, the highest index wins. A write clears that register's busy bit.
//  - hazard(x) = busy[x] && !(wb hit on x this cycle).
//  - stall = iss_valid && ((rs_use && hazard(rs)) || (rt_use && hazard(rt)) ||
//    (iss_rw is GPR/FPR && hazard({bank,iss_rd}))). The last term is the WAW check.
//  - An instruction is accepted on iss_valid && !stall. If accepted with a writing iss_rw (excluding a
//    dropped GPR[0]), it sets busy[{bank,iss_rd}] at posedge.
//  - Set and clear on the same register in the same cycle: set wins, because the issued write is newer.
//  - A write-back to a non-busy register is legal (zero-latency ALU path). It updates data only.
//  - pending is registered and tracks the popcount of busy bits every cycle. Accept and clear on
//    different registers in one cycle leave it net unchanged.
//  - iss_valid=0 forces stall=0 and changes no state.
//  - rst asserted mid-operation: busy bits clear immediately and in-flight write-backs are lost.
//    The data array returns to reset values.
//  - No latency from write-back to read (forwarding). Scoreboard update latency is 1 cycle.
// STRUCTURE
//  - Package constant gains: typedef enum logic [1:0] {RW_NONE, RW_GPR, RW_FPR} rw_t;
//    typedef logic [5:0] reg_addr_t; localparams for SP/HP indices and init values.
//  - One sub-module, rf_bypass: combinational NWB-port priority forward mux. Instantiated twice (s, t).
//  - The array is a distributed-RAM-style 2*NREG x XLEN register set. Busy is a 2*NREG flop vector.
// TESTING
//  - Reset: rst=1 -> GPR29=0x30, GPR28=0xF4240, dbg_reg=GPR2=0, idle=1, stall=0.
//  - RAW: issue rw=FPR rd=5 -> next cycle rs_addr={1,5}, rs_use=1 -> stall=1. wb FPR5=0x3F800000
//    -> same cycle stall=0 and s_data=0x3F800000.
//  - WAW: GPR7 busy; issue rw=GPR rd=7 -> stall=1 until wb GPR7. Then accept -> busy set again, pending=1.
//  - Port priority: wb0 and wb1 both write GPR4 (0x11, 0x22) -> read returns 0x22 same cycle
//    and from the array after the edge.
//  - Zero register: wb GPR0=0xFFFF and issue rd=0 rw=GPR -> s_data for {0,0} stays 0, pending unchanged.
//  - Async reset mid-op: 3 regs busy, pulse rst between edges -> pending=0 and stall=0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and defaults for the decode-stage register file and busy scoreboard.
package regfile_scoreboard_pkg;

    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_GPR  = 2'b01,
        RW_FPR  = 2'b10
    } rw_t;

    typedef logic [5:0] reg_addr_t;

    localparam int unsigned DEF_SP_IDX  = 29;
    localparam logic [31:0] DEF_SP_INIT = 32'h0000_0030;
    localparam int unsigned DEF_HP_IDX  = 28;
    localparam logic [31:0] DEF_HP_INIT = 32'h000F_4240;

    // Encoding 11 is treated as "no destination" everywhere.
    function automatic logic rw_writes(logic [1:0] rw);
        return (rw == RW_GPR) || (rw == RW_FPR);
    endfunction

    function automatic logic rw_bank(logic [1:0] rw);
        return rw == RW_FPR;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_bypass.sv
// rf_bypass: priority forward mux from the write-back ports onto one read port.
module rf_bypass
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NWB     = 2,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic [AW:0]         addr,
    input  logic [XLEN-1:0]     arr_data,
    input  logic [NWB-1:0]      wb_valid,
    input  logic [2*NWB-1:0]    wb_rw,
    input  logic [AW*NWB-1:0]   wb_rd,
    input  logic [XLEN*NWB-1:0] wb_data,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    always_comb begin
        hit  = 1'b0;
        data = arr_data;
        // Ascending scan so the highest-index hitting port wins.
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && rw_writes(wb_rw[2*i +: 2]) &&
                rw_bank(wb_rw[2*i +: 2]) == addr[AW] &&
                wb_rd[AW*i +: AW] == addr[AW-1:0]) begin
                hit  = 1'b1;
                data = wb_data[XLEN*i +: XLEN];
            end
        end
        if (ZERO_R0 && addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR/FPR register file with multi-port write-back, forwarding and a busy scoreboard driving stall.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned NWB     = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter int unsigned SP_IDX  = DEF_SP_IDX,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(DEF_SP_INIT),
    parameter int unsigned HP_IDX  = DEF_HP_IDX,
    parameter logic [XLEN-1:0] HP_INIT = XLEN'(DEF_HP_INIT),
    parameter int unsigned DBG_IDX = 2,
    localparam int unsigned AW     = $clog2(NREG),
    localparam int unsigned PW     = $clog2(2*NREG+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW:0]         rs_addr,
    input  logic                rs_use,
    input  logic [AW:0]         rt_addr,
    input  logic                rt_use,
    output logic [XLEN-1:0]     s_data,
    output logic [XLEN-1:0]     t_data,
    input  logic                iss_valid,
    input  logic [1:0]          iss_rw,
    input  logic [AW-1:0]       iss_rd,
    output logic                stall,
    input  logic [NWB-1:0]      wb_valid,
    input  logic [2*NWB-1:0]    wb_rw,
    input  logic [AW*NWB-1:0]   wb_rd,
    input  logic [XLEN*NWB-1:0] wb_data,
    output logic [PW-1:0]       pending,
    output logic                idle,
    output logic [XLEN-1:0]     dbg_reg
);

    localparam int unsigned NENT = 2 * NREG;

    logic [XLEN-1:0] regs_q [NENT];
    logic [XLEN-1:0] regs_d [NENT];
    logic [NENT-1:0] busy_q, busy_d;
    logic [PW-1:0]   pending_q, pending_d;

    logic            rs_hit, rt_hit, rd_hit;
    logic [AW:0]     rd_addr;
    logic            iss_wr;

    rf_bypass #(.XLEN(XLEN), .AW(AW), .NWB(NWB), .ZERO_R0(ZERO_R0)) u_bypass_s (
        .addr     (rs_addr),
        .arr_data (regs_q[rs_addr]),
        .wb_valid (wb_valid),
        .wb_rw    (wb_rw),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .hit      (rs_hit),
        .data     (s_data)
    );

    rf_bypass #(.XLEN(XLEN), .AW(AW), .NWB(NWB), .ZERO_R0(ZERO_R0)) u_bypass_t (
        .addr     (rt_addr),
        .arr_data (regs_q[rt_addr]),
        .wb_valid (wb_valid),
        .wb_rw    (wb_rw),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .hit      (rt_hit),
        .data     (t_data)
    );

    assign rd_addr = {rw_bank(iss_rw), iss_rd};
    // A dropped GPR[0] destination never occupies the scoreboard.
    assign iss_wr  = rw_writes(iss_rw) && !(ZERO_R0 && rd_addr == '0);

    always_comb begin
        rd_hit = 1'b0;
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && rw_writes(wb_rw[2*i +: 2]) &&
                rw_bank(wb_rw[2*i +: 2]) == rd_addr[AW] &&
                wb_rd[AW*i +: AW] == iss_rd) begin
                rd_hit = 1'b1;
            end
        end
    end

    assign stall = iss_valid &&
                   ((rs_use && busy_q[rs_addr] && !rs_hit) ||
                    (rt_use && busy_q[rt_addr] && !rt_hit) ||
                    (rw_writes(iss_rw) && busy_q[rd_addr] && !rd_hit));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && rw_writes(wb_rw[2*i +: 2]) &&
                !(ZERO_R0 && !rw_bank(wb_rw[2*i +: 2]) && wb_rd[AW*i +: AW] == '0)) begin
                regs_d[{rw_bank(wb_rw[2*i +: 2]), wb_rd[AW*i +: AW]}] = wb_data[XLEN*i +: XLEN];
                busy_d[{rw_bank(wb_rw[2*i +: 2]), wb_rd[AW*i +: AW]}] = 1'b0;
            end
        end
        // Applied after the clears: the newly issued write is younger than any returning one.
        if (iss_valid && !stall && iss_wr) begin
            busy_d[rd_addr] = 1'b1;
        end
        pending_d = '0;
        for (int i = 0; i < NENT; i++) begin
            pending_d = pending_d + PW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[SP_IDX] <= SP_INIT;
            regs_q[HP_IDX] <= HP_INIT;
            busy_q         <= '0;
            pending_q      <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
    assign idle    = (pending_q == '0);
    assign dbg_reg = regs_q[DBG_IDX];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rs_addr, rt_addr;
    logic        rs_use, rt_use;
    logic [31:0] s_data, t_data;
    logic        iss_valid;
    logic [1:0]  iss_rw;
    logic [4:0]  iss_rd;
    logic        stall;
    logic [1:0]  wb_valid;
    logic [3:0]  wb_rw;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;
    logic [6:0]  pending;
    logic        idle;
    logic [31:0] dbg_reg;

    int checks = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rs_use    (rs_use),
        .rt_addr   (rt_addr),
        .rt_use    (rt_use),
        .s_data    (s_data),
        .t_data    (t_data),
        .iss_valid (iss_valid),
        .iss_rw    (iss_rw),
        .iss_rd    (iss_rd),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rw     (wb_rw),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .pending   (pending),
        .idle      (idle),
        .dbg_reg   (dbg_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        wb_valid = '0;
        wb_rw    = '0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    task automatic set_wb(input int p, input logic [1:0] rw, input logic [4:0] rd,
                          input logic [31:0] d);
        wb_valid[p]        = 1'b1;
        wb_rw[2*p +: 2]    = rw;
        wb_rd[5*p +: 5]    = rd;
        wb_data[32*p +: 32] = d;
    endtask

    task automatic issue(input logic v, input logic [1:0] rw, input logic [4:0] rd);
        iss_valid = v;
        iss_rw    = rw;
        iss_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = 6'd29; rt_addr = 6'd28; rs_use = 1'b0; rt_use = 1'b0;
        issue(1'b0, RW_NONE, 5'd0);
        clr_wb();
        tick();
        chk("rst_sp", s_data, 32'h30);
        chk("rst_hp", t_data, 32'h000F4240);
        chk("rst_dbg", dbg_reg, 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        tick();

        // RAW on FPR5
        issue(1'b1, RW_FPR, 5'd5);
        #1 chk("raw_issue_stall", 32'(stall), 32'h0);
        tick();
        chk("raw_pending", 32'(pending), 32'h1);
        chk("raw_idle", 32'(idle), 32'h0);
        issue(1'b1, RW_NONE, 5'd0);
        rs_addr = {1'b1, 5'd5}; rs_use = 1'b1;
        #1 chk("raw_stall", 32'(stall), 32'h1);
        set_wb(0, RW_FPR, 5'd5, 32'h3F800000);
        #1 chk("raw_wb_stall", 32'(stall), 32'h0);
        chk("raw_fwd", s_data, 32'h3F800000);
        tick();
        clr_wb();
        issue(1'b0, RW_NONE, 5'd0);
        rs_use = 1'b0;
        #1 chk("raw_arr", s_data, 32'h3F800000);
        chk("raw_cleared", 32'(pending), 32'h0);

        // WAW on GPR7
        issue(1'b1, RW_GPR, 5'd7);
        tick();
        chk("waw_busy", 32'(pending), 32'h1);
        #1 chk("waw_stall", 32'(stall), 32'h1);
        tick();
        chk("waw_hold", 32'(stall), 32'h1);
        chk("waw_hold_pend", 32'(pending), 32'h1);
        set_wb(1, RW_GPR, 5'd7, 32'h77);
        #1 chk("waw_release", 32'(stall), 32'h0);
        tick();
        clr_wb();
        issue(1'b0, RW_NONE, 5'd0);
        rs_addr = {1'b0, 5'd7};
        #1 chk("waw_reset_busy", 32'(pending), 32'h1);
        chk("waw_data", s_data, 32'h77);
        set_wb(0, RW_GPR, 5'd7, 32'h78);
        tick();
        clr_wb();
        chk("waw_drain", 32'(idle), 32'h1);

        // Port priority on GPR4, and dbg_reg on GPR2
        rs_addr = {1'b0, 5'd4};
        set_wb(0, RW_GPR, 5'd4, 32'h11);
        set_wb(1, RW_GPR, 5'd4, 32'h22);
        #1 chk("prio_fwd", s_data, 32'h22);
        tick();
        clr_wb();
        #1 chk("prio_arr", s_data, 32'h22);
        set_wb(1, RW_GPR, 5'd2, 32'hABCD);
        #1 chk("dbg_pre", dbg_reg, 32'h0);
        tick();
        clr_wb();
        chk("dbg_post", dbg_reg, 32'hABCD);

        // Zero register
        rs_addr = 6'd0;
        set_wb(0, RW_GPR, 5'd0, 32'hFFFF);
        issue(1'b1, RW_GPR, 5'd0);
        #1 chk("zero_fwd", s_data, 32'h0);
        chk("zero_stall", 32'(stall), 32'h0);
        tick();
        clr_wb();
        issue(1'b0, RW_NONE, 5'd0);
        #1 chk("zero_arr", s_data, 32'h0);
        chk("zero_pending", 32'(pending), 32'h0);

        // rw=11 is no write and no busy
        rs_addr = {1'b0, 5'd8}; rt_addr = {1'b1, 5'd8};
        set_wb(0, 2'b11, 5'd8, 32'hDEAD);
        issue(1'b1, 2'b11, 5'd9);
        tick();
        clr_wb();
        issue(1'b0, RW_NONE, 5'd0);
        #1 chk("rw3_gpr", s_data, 32'h0);
        chk("rw3_fpr", t_data, 32'h0);
        chk("rw3_pending", 32'(pending), 32'h0);

        // Async reset mid-operation
        issue(1'b1, RW_GPR, 5'd10);
        tick();
        issue(1'b1, RW_FPR, 5'd11);
        tick();
        issue(1'b1, RW_GPR, 5'd12);
        tick();
        chk("ar_pending", 32'(pending), 32'h3);
        issue(1'b1, RW_NONE, 5'd0);
        rs_addr = {1'b0, 5'd10}; rs_use = 1'b1;
        rt_addr = {1'b0, 5'd4};
        #1 chk("ar_stall_pre", 32'(stall), 32'h1);
        #1 rst = 1'b1;
        #1 chk("ar_pending_now", 32'(pending), 32'h0);
        chk("ar_stall_now", 32'(stall), 32'h0);
        chk("ar_array", t_data, 32'h0);
        rst = 1'b0;
        issue(1'b0, RW_NONE, 5'd0);
        rs_use = 1'b0;
        rs_addr = 6'd29;
        tick();
        chk("ar_sp", s_data, 32'h30);
        chk("ar_idle", 32'(idle), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
